// File: rtl/prog_sequencer_pkg.sv
// Shared types and defaults for the program sequencer.
package prog_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    localparam int PC_W_DEFAULT = 12;

endpackage

// File: rtl/jump_lut.sv
// Jump-target table: 2^L x D registers, one write port, combinational read.
module jump_lut
    import prog_sequencer_pkg::*;
#(
    parameter int D = PC_W_DEFAULT,
    parameter int L = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic [L-1:0] waddr,
    input  logic [D-1:0] wdata,
    input  logic [L-1:0] raddr,
    output logic [D-1:0] rdata
);

    logic [D-1:0] mem [2**L];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2**L; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read sees the pre-write value on a same-edge write, so a jump uses the old entry.
    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_sequencer.sv
// Program counter, jump-target table and req/done run handshake.
//
// state   | meaning
// IDLE    | waiting for req, prog_ctr held
// RUN     | PC advancing, cycle_cnt counting every edge
// DONE    | run finished, outputs held until req drops
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter int D          = PC_W_DEFAULT,
    parameter int L          = 5,
    parameter int START_ADDR = 0,
    parameter int DONE_ADDR  = 128,
    parameter int CW         = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    output logic          done,
    output logic          busy,
    input  logic          stall,
    input  logic          halt,
    input  logic          reljump_en,
    input  logic          absjump_en,
    input  logic [L-1:0]  lut_idx,
    input  logic          lut_we,
    input  logic [L-1:0]  lut_waddr,
    input  logic [D-1:0]  lut_wdata,
    output logic [D-1:0]  prog_ctr,
    output logic [CW-1:0] cycle_cnt
);

    seq_state_e    state, state_nxt;
    logic [D-1:0]  pc_nxt;
    logic [CW-1:0] cnt_nxt;
    logic [D-1:0]  lut_rdata;

    jump_lut #(.D(D), .L(L)) u_lut (
        .clk   (clk),
        .reset (reset),
        .we    (lut_we),
        .waddr (lut_waddr),
        .wdata (lut_wdata),
        .raddr (lut_idx),
        .rdata (lut_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            prog_ctr  <= '0;
            cycle_cnt <= '0;
        end else begin
            state     <= state_nxt;
            prog_ctr  <= pc_nxt;
            cycle_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = prog_ctr;
        cnt_nxt   = cycle_cnt;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt = ST_RUN;
                    pc_nxt    = D'(START_ADDR);
                    cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                cnt_nxt = (cycle_cnt == {CW{1'b1}}) ? cycle_cnt : cycle_cnt + 1'b1;
                if (halt) begin
                    state_nxt = ST_DONE;
                end else if (!stall) begin
                    // Relative entries are two's complement; the D-bit sum wraps both ways.
                    if (absjump_en)      pc_nxt = lut_rdata;
                    else if (reljump_en) pc_nxt = prog_ctr + lut_rdata;
                    else                 pc_nxt = prog_ctr + 1'b1;
                    if (pc_nxt == D'(DONE_ADDR)) state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!req) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        done = (state == ST_DONE);
        busy = (state == ST_RUN);
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: vector table plus hand-written corner sequences.
module tb_prog_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0, stall = 1'b0, halt = 1'b0;
    logic        reljump_en = 1'b0, absjump_en = 1'b0;
    logic [4:0]  lut_idx = '0, lut_waddr = '0;
    logic        lut_we = 1'b0;
    logic [11:0] lut_wdata = '0;
    logic        done, busy;
    logic [11:0] prog_ctr;
    logic [15:0] cycle_cnt;

    logic        req4 = 1'b0;
    logic        done4, busy4;
    logic [11:0] prog_ctr4;
    logic [3:0]  cycle_cnt4;
    logic        zero1 = 1'b0;
    logic [4:0]  zero5 = '0;
    logic [11:0] zero12 = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prog_sequencer dut (
        .clk(clk), .reset(reset), .req(req), .done(done), .busy(busy),
        .stall(stall), .halt(halt), .reljump_en(reljump_en), .absjump_en(absjump_en),
        .lut_idx(lut_idx), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .prog_ctr(prog_ctr), .cycle_cnt(cycle_cnt)
    );

    prog_sequencer #(.CW(4)) dut4 (
        .clk(clk), .reset(reset), .req(req4), .done(done4), .busy(busy4),
        .stall(zero1), .halt(zero1), .reljump_en(zero1), .absjump_en(zero1),
        .lut_idx(zero5), .lut_we(zero1), .lut_waddr(zero5), .lut_wdata(zero12),
        .prog_ctr(prog_ctr4), .cycle_cnt(cycle_cnt4)
    );

    typedef struct {
        logic        req, stall, halt, abs_en, rel_en;
        logic [4:0]  idx;
        logic        we;
        logic [4:0]  waddr;
        logic [11:0] wdata;
        logic [11:0] exp_pc;
        logic        exp_done, exp_busy;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(logic r, logic s, logic h, logic a, logic rl, logic [4:0] i,
                                logic w, logic [4:0] wa, logic [11:0] wd,
                                logic [11:0] pc, logic dn, logic bs, logic [15:0] cn);
        vec_t v;
        v.req = r; v.stall = s; v.halt = h; v.abs_en = a; v.rel_en = rl; v.idx = i;
        v.we = w; v.waddr = wa; v.wdata = wd;
        v.exp_pc = pc; v.exp_done = dn; v.exp_busy = bs; v.exp_cnt = cn;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; halt = 0; reljump_en = 0; absjump_en = 0;
        lut_idx = '0; lut_we = 0; lut_waddr = '0; lut_wdata = '0;
    endtask

    initial begin
        // Row columns: req stall halt abs rel idx | we waddr wdata | pc done busy cnt
        vecs[0]  = mk(1,0,0,0,0,0, 1,3,12'hFFE, 12'h000,0,1,0);
        vecs[1]  = mk(1,0,0,0,0,0, 1,4,12'd50,  12'h001,0,1,1);
        vecs[2]  = mk(1,0,0,0,0,0, 1,2,12'd20,  12'h002,0,1,2);
        vecs[3]  = mk(1,0,0,0,0,0, 1,5,12'hFFF, 12'h003,0,1,3);
        vecs[4]  = mk(1,0,0,0,0,0, 1,1,12'h001, 12'h004,0,1,4);
        vecs[5]  = mk(1,0,0,0,0,0, 1,6,12'd10,  12'h005,0,1,5);
        vecs[6]  = mk(1,0,0,1,0,6, 0,0,0,       12'd10, 0,1,6);
        vecs[7]  = mk(0,0,0,0,1,3, 0,0,0,       12'd8,  0,1,7);
        vecs[8]  = mk(1,0,0,1,1,4, 0,0,0,       12'd50, 0,1,8);
        vecs[9]  = mk(1,0,0,1,0,5, 0,0,0,       12'hFFF,0,1,9);
        vecs[10] = mk(1,0,0,0,0,0, 0,0,0,       12'h000,0,1,10);
        vecs[11] = mk(1,0,0,1,0,5, 0,0,0,       12'hFFF,0,1,11);
        vecs[12] = mk(1,0,0,0,1,1, 0,0,0,       12'h000,0,1,12);
        vecs[13] = mk(1,0,0,0,1,3, 0,0,0,       12'hFFE,0,1,13);
        vecs[14] = mk(1,0,0,1,0,2, 1,2,12'd40,  12'd20, 0,1,14);
        vecs[15] = mk(1,0,0,1,0,2, 0,0,0,       12'd40, 0,1,15);
        vecs[16] = mk(1,1,0,1,0,4, 0,0,0,       12'd40, 0,1,16);
        vecs[17] = mk(1,1,0,1,0,4, 0,0,0,       12'd40, 0,1,17);
        vecs[18] = mk(1,1,0,1,0,4, 0,0,0,       12'd40, 0,1,18);
        vecs[19] = mk(1,1,1,1,0,4, 0,0,0,       12'd40, 1,0,19);
        vecs[20] = mk(1,0,0,0,0,0, 0,0,0,       12'd40, 1,0,19);
        vecs[21] = mk(0,0,0,0,0,0, 0,0,0,       12'd40, 0,0,19);
        vecs[22] = mk(0,0,0,0,0,0, 0,0,0,       12'd40, 0,0,19);

        #1 reset = 0;
        #1;
        chk("rst_pc",   prog_ctr, 0);
        chk("rst_cnt",  cycle_cnt, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        #21 reset = 1;

        // Straight-line run 0..128 with no jumps.
        req = 1;
        step();
        chk("run_start_pc", prog_ctr, 0);
        chk("run_start_busy", busy, 1);
        chk("run_start_cnt", cycle_cnt, 0);
        for (int k = 1; k <= 128; k++) begin
            step();
            chk("run_pc", prog_ctr, k);
            chk("run_done", done, (k == 128) ? 1 : 0);
        end
        chk("run_end_cnt", cycle_cnt, 128);
        chk("run_end_busy", busy, 0);
        step();
        chk("done_held", done, 1);
        chk("done_held_pc", prog_ctr, 128);
        req = 0;
        step();
        chk("back_idle_done", done, 0);
        chk("back_idle_busy", busy, 0);
        chk("idle_pc_hold", prog_ctr, 128);

        // Table-driven jump / stall / halt run.
        for (int i = 0; i < 23; i++) begin
            req = vecs[i].req; stall = vecs[i].stall; halt = vecs[i].halt;
            absjump_en = vecs[i].abs_en; reljump_en = vecs[i].rel_en; lut_idx = vecs[i].idx;
            lut_we = vecs[i].we; lut_waddr = vecs[i].waddr; lut_wdata = vecs[i].wdata;
            step();
            chk($sformatf("vec%0d_pc", i),   prog_ctr,  vecs[i].exp_pc);
            chk($sformatf("vec%0d_done", i), done,      vecs[i].exp_done);
            chk($sformatf("vec%0d_busy", i), busy,      vecs[i].exp_busy);
            chk($sformatf("vec%0d_cnt", i),  cycle_cnt, vecs[i].exp_cnt);
        end
        idle_inputs();

        // Asynchronous reset mid-run at prog_ctr 57 also clears the LUT.
        req = 1;
        step();
        for (int k = 1; k <= 57; k++) step();
        chk("pre_reset_pc", prog_ctr, 57);
        #2 reset = 0;
        #1;
        chk("async_rst_pc",   prog_ctr, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_cnt",  cycle_cnt, 0);
        #1 reset = 1;
        step();
        chk("rerun_pc", prog_ctr, 0);
        chk("rerun_busy", busy, 1);
        absjump_en = 1; lut_idx = 2;
        step();
        chk("lut2_cleared", prog_ctr, 0);
        lut_idx = 4;
        step();
        chk("lut4_cleared", prog_ctr, 0);
        idle_inputs();
        req = 0;

        // CW=4 instance: 20 RUN edges, counter pins at 15.
        req4 = 1;
        step();
        chk("cw4_start_cnt", cycle_cnt4, 0);
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("cw4_cnt", cycle_cnt4, (k > 15) ? 15 : k);
        end
        chk("cw4_pc", prog_ctr4, 20);
        chk("cw4_busy", busy4, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
